// File: rtl/imem_sp_ram_if.sv
// Loader and fetch bus between the boot loader / CPU fetch stage (master)
// and the instruction memory (slave).
interface imem_sp_ram_if #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 8
);
  logic              ld_start;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;
  logic [ADDR_W:0]   ld_cnt;
  logic              ld_err;
  logic              run;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rsp_valid;
  logic              if_rsp_ready;
  logic [DATA_W-1:0] if_rsp_data;
  logic              if_rsp_err;

  modport master (
    output ld_start, ld_we, ld_addr, ld_data, ld_done,
    output if_req_valid, if_addr, if_rsp_ready,
    input  ld_cnt, ld_err, run,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err
  );

  modport slave (
    input  ld_start, ld_we, ld_addr, ld_data, ld_done,
    input  if_req_valid, if_addr, if_rsp_ready,
    output ld_cnt, ld_err, run,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err
  );
endinterface

// File: rtl/imem_sp_ram.sv
// Single-port instruction memory: runtime program load, then registered
// back-pressured fetch with 1-cycle latency and out-of-range flagging.
module imem_sp_ram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input logic          clk,
  input logic          rst,
  imem_sp_ram_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic              run_q;
  logic [ADDR_W:0]   ld_cnt_q;
  logic              ld_err_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic ld_in_range, if_in_range, mem_we, req_ready, accept;

  assign ld_in_range = ({1'b0, bus.ld_addr} < DEPTH_C);
  assign if_in_range = ({1'b0, bus.if_addr} < DEPTH_C);
  // ld_start wins over a coincident write so ld_cnt always matches words written
  assign mem_we      = (state_q == S_LOAD) & ~bus.ld_start & bus.ld_we & ld_in_range;
  assign req_ready   = run_q & (~rsp_valid_q | bus.if_rsp_ready);
  assign accept      = bus.if_req_valid & req_ready;

  // Array deliberately has no reset so a loaded program survives rst
  always_ff @(posedge clk) begin
    if (mem_we) mem[bus.ld_addr] <= bus.ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      ld_cnt_q    <= '0;
      ld_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else if (bus.ld_start) begin
      state_q     <= S_LOAD;
      run_q       <= 1'b0;
      ld_cnt_q    <= '0;
      ld_err_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (bus.ld_we) begin
            if (!ld_in_range)            ld_err_q <= 1'b1;
            else if (ld_cnt_q != DEPTH_C) ld_cnt_q <= ld_cnt_q + 1'b1;
          end
          if (bus.ld_done) begin
            state_q <= S_RUN;
            run_q   <= 1'b1;
          end
        end
        S_RUN: begin
          if (accept) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= if_in_range ? mem[bus.if_addr] : '0;
            rsp_err_q   <= ~if_in_range;
          end else if (bus.if_rsp_ready) begin
            rsp_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ld_cnt       = ld_cnt_q;
  assign bus.ld_err       = ld_err_q;
  assign bus.run          = run_q;
  assign bus.if_req_ready = req_ready;
  assign bus.if_rsp_valid = rsp_valid_q;
  assign bus.if_rsp_data  = rsp_data_q;
  assign bus.if_rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_imem_sp_ram.sv
// Drives a full-depth (256) and a short (200) memory with identical stimulus and
// checks both against a per-instance behavioural model of the loader/fetch rules.
module tb_imem_sp_ram;
  localparam int unsigned DW = 24;
  localparam int unsigned AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          ld_start, ld_we, ld_done;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          req_valid, rsp_ready;
  logic [AW-1:0] if_addr;

  imem_sp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  imem_sp_ram_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  assign ifa.ld_start = ld_start;  assign ifb.ld_start = ld_start;
  assign ifa.ld_we    = ld_we;     assign ifb.ld_we    = ld_we;
  assign ifa.ld_addr  = ld_addr;   assign ifb.ld_addr  = ld_addr;
  assign ifa.ld_data  = ld_data;   assign ifb.ld_data  = ld_data;
  assign ifa.ld_done  = ld_done;   assign ifb.ld_done  = ld_done;
  assign ifa.if_req_valid = req_valid;  assign ifb.if_req_valid = req_valid;
  assign ifa.if_addr      = if_addr;    assign ifb.if_addr      = if_addr;
  assign ifa.if_rsp_ready = rsp_ready;  assign ifb.if_rsp_ready = rsp_ready;

  imem_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256)) u_a (.clk(clk), .rst(rst), .bus(ifa));
  imem_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200)) u_b (.clk(clk), .rst(rst), .bus(ifb));

  int errors = 0;
  int checks = 0;

  // Model: mode 0=idle 1=load 2=run, per instance
  int            dep    [2] = '{256, 200};
  int            m_mode [2];
  int            m_cnt  [2];
  bit            m_run  [2];
  bit            m_err  [2];
  bit            m_vld  [2];
  bit            m_rerr [2];
  logic [DW-1:0] m_data [2];
  logic [DW-1:0] m_mem  [2][256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic obs_of(input int k, output logic rdy, output logic run, output logic [AW:0] cnt,
                        output logic err, output logic vld, output logic [DW-1:0] data,
                        output logic rerr);
    if (k == 0) begin
      rdy = ifa.if_req_ready; run = ifa.run; cnt = ifa.ld_cnt; err = ifa.ld_err;
      vld = ifa.if_rsp_valid; data = ifa.if_rsp_data; rerr = ifa.if_rsp_err;
    end else begin
      rdy = ifb.if_req_ready; run = ifb.run; cnt = ifb.ld_cnt; err = ifb.ld_err;
      vld = ifb.if_rsp_valid; data = ifb.if_rsp_data; rerr = ifb.if_rsp_err;
    end
  endtask

  task automatic model_step(input int k);
    bit ready;
    ready = m_run[k] && (!m_vld[k] || rsp_ready);
    if (rst) begin
      m_mode[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      m_vld[k] = 0; m_data[k] = '0; m_rerr[k] = 0;
    end else if (ld_start) begin
      m_mode[k] = 1; m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 0; m_vld[k] = 0;
    end else if (m_mode[k] == 1) begin
      if (ld_we) begin
        if (int'(ld_addr) < dep[k]) begin
          m_mem[k][ld_addr] = ld_data;
          m_cnt[k] = (m_cnt[k] + 1 > dep[k]) ? dep[k] : m_cnt[k] + 1;
        end else m_err[k] = 1;
      end
      if (ld_done) begin m_mode[k] = 2; m_run[k] = 1; end
    end else if (m_mode[k] == 2) begin
      if (req_valid && ready) begin
        m_vld[k]  = 1;
        m_rerr[k] = !(int'(if_addr) < dep[k]);
        m_data[k] = m_rerr[k] ? '0 : m_mem[k][if_addr];
      end else if (rsp_ready) m_vld[k] = 0;
    end
  endtask

  // One clock: check comb ready, advance model, clock, check registered outputs
  task automatic tick();
    logic rdy, run, err, vld, rerr;
    logic [AW:0] cnt;
    logic [DW-1:0] data;
    #1;
    for (int k = 0; k < 2; k++) begin
      obs_of(k, rdy, run, cnt, err, vld, data, rerr);
      chk($sformatf("req_ready[%0d]", k), 32'(rdy), 32'(m_run[k] && (!m_vld[k] || rsp_ready)));
      model_step(k);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      obs_of(k, rdy, run, cnt, err, vld, data, rerr);
      chk($sformatf("run[%0d]", k),       32'(run),  32'(m_run[k]));
      chk($sformatf("ld_cnt[%0d]", k),    32'(cnt),  32'(m_cnt[k]));
      chk($sformatf("ld_err[%0d]", k),    32'(err),  32'(m_err[k]));
      chk($sformatf("rsp_valid[%0d]", k), 32'(vld),  32'(m_vld[k]));
      chk($sformatf("rsp_data[%0d]", k),  32'(data), 32'(m_data[k]));
      chk($sformatf("rsp_err[%0d]", k),   32'(rerr), 32'(m_rerr[k]));
    end
  endtask

  task automatic idle_inputs();
    ld_start = 0; ld_we = 0; ld_done = 0; ld_addr = '0; ld_data = '0;
    req_valid = 0; if_addr = '0; rsp_ready = 0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_run[k] = 0; m_cnt[k] = 0; m_err[k] = 0;
      m_vld[k] = 0; m_data[k] = '0; m_rerr[k] = 0;
    end
    idle_inputs();
    rst = 1;
    tick(); tick();
    chk("reset_run", 32'(ifa.run), 0);
    chk("reset_vld", 32'(ifa.if_rsp_valid), 0);
    rst = 0;

    // T1: load four words
    ld_start = 1; tick(); ld_start = 0;
    for (int i = 0; i < 4; i++) begin
      ld_we = 1; ld_addr = AW'(i); ld_data = DW'(i + 1); tick();
    end
    ld_we = 0; ld_done = 1; tick(); ld_done = 0;
    chk("T1_cnt", 32'(ifa.ld_cnt), 4);
    chk("T1_err", 32'(ifa.ld_err), 0);
    chk("T1_run", 32'(ifa.run), 1);

    // T2: back-to-back fetches
    rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; if_addr = AW'(i); tick();
      chk($sformatf("T2_data%0d", i), 32'(ifa.if_rsp_data), 32'(i + 1));
      chk($sformatf("T2_vld%0d", i), 32'(ifa.if_rsp_valid), 1);
    end
    req_valid = 0; tick();

    // T3: back-pressure holds response
    req_valid = 1; if_addr = 8'd2; rsp_ready = 0; tick();
    if_addr = 8'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("T3_hold_data", 32'(ifa.if_rsp_data), 3);
      chk("T3_hold_rdy", 32'(ifa.if_req_ready), 0);
    end
    rsp_ready = 1; #1;
    chk("T3_release_rdy", 32'(ifa.if_req_ready), 1);
    tick();
    chk("T3_next_data", 32'(ifa.if_rsp_data), 4);
    req_valid = 0; tick();

    // T4: out-of-range on the 200-deep instance
    ld_start = 1; tick(); ld_start = 0;
    ld_we = 1; ld_addr = 8'd10; ld_data = 24'h00000b; tick();
    ld_addr = 8'd210; ld_data = 24'h000005; tick();
    chk("T4_b_err", 32'(ifb.ld_err), 1);
    chk("T4_b_cnt", 32'(ifb.ld_cnt), 1);
    chk("T4_a_cnt", 32'(ifa.ld_cnt), 2);
    ld_we = 0; ld_done = 1; tick(); ld_done = 0;
    req_valid = 1; if_addr = 8'd210; rsp_ready = 1; tick();
    chk("T4_b_rsp_err", 32'(ifb.if_rsp_err), 1);
    chk("T4_b_rsp_data", 32'(ifb.if_rsp_data), 0);
    chk("T4_a_rsp_data", 32'(ifa.if_rsp_data), 5);
    req_valid = 0; tick();

    // T5: ld_start drops a stalled response; ld_start beats ld_done
    req_valid = 1; if_addr = 8'd1; rsp_ready = 0; tick();
    req_valid = 0; ld_start = 1; tick();
    chk("T5_vld", 32'(ifa.if_rsp_valid), 0);
    chk("T5_run", 32'(ifa.run), 0);
    ld_done = 1; tick();
    ld_start = 0; ld_done = 0; tick();
    chk("T5_cnt", 32'(ifa.ld_cnt), 0);
    chk("T5_still_load", 32'(ifa.run), 0);
    ld_done = 1; tick(); ld_done = 0;

    // T6: reset in RUN keeps memory contents
    rst = 1; tick(); rst = 0;
    chk("T6_rst_run", 32'(ifa.run), 0);
    ld_start = 1; tick(); ld_start = 0;
    ld_done = 1; tick(); ld_done = 0;
    req_valid = 1; if_addr = 8'd1; rsp_ready = 1; tick();
    chk("T6_data", 32'(ifa.if_rsp_data), 2);
    req_valid = 0; tick();

    // Random program over full address space, then rewrites to hit saturation
    ld_start = 1; tick(); ld_start = 0;
    for (int i = 0; i < 256; i++) begin
      ld_we = 1; ld_addr = AW'(i); ld_data = DW'($urandom); tick();
    end
    for (int i = 0; i < 3; i++) begin
      ld_addr = AW'($urandom_range(0, 199)); ld_data = DW'($urandom); tick();
    end
    chk("sat_a", 32'(ifa.ld_cnt), 256);
    chk("sat_b", 32'(ifb.ld_cnt), 200);
    ld_we = 0; ld_done = 1; tick(); ld_done = 0;

    for (int i = 0; i < 300; i++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      if_addr   = AW'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    idle_inputs();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
